// File: rtl/pixel_normalizer_pkg.sv
`default_nettype none
// pixel_normalizer_pkg -- shared Q2.16 scale widths, mode encodings and the mode-0 scale helper.
// Revision: 1.0
package pixel_normalizer_pkg;

  localparam int SCALE_W    = 18;
  localparam int SCALE_FRAC = 16;

  typedef enum logic {
    MODE_FULL = 1'b0,
    MODE_NORM = 1'b1
  } mode_e;

  // round(2^16 / (2^in_w - 1)) using integer arithmetic: floor((2a + b) / 2b)
  function automatic logic [SCALE_W-1:0] mode0_scale(input int in_w);
    longint den;
    den = (longint'(1) << in_w) - 1;
    return SCALE_W'(((longint'(1) << (SCALE_FRAC + 1)) + den) / (2 * den));
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_normalizer_if.sv
`default_nettype none
// pixel_normalizer_if -- input/output stream handshake bundle for pixel_normalizer.
// Revision: 1.0
interface pixel_normalizer_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
);

  logic             s_valid;
  logic             s_ready;
  logic [IN_W-1:0]  s_data;
  logic             s_sof;
  logic             m_valid;
  logic             m_ready;
  logic [OUT_W-1:0] m_data;
  logic [1:0]       m_ch;

  modport master (
    output s_valid, s_data, s_sof, m_ready,
    input  s_ready, m_valid, m_data, m_ch
  );

  modport slave (
    input  s_valid, s_data, s_sof, m_ready,
    output s_ready, m_valid, m_data, m_ch
  );

endinterface
`default_nettype wire

// File: rtl/pixel_normalizer_round_sat.sv
`default_nettype none
// norm_round_sat -- combinational round-half-up shift from Q.16 to Q.OUT_FRAC plus signed saturation.
// Revision: 1.0
module norm_round_sat #(
  parameter int P_W      = 28,
  parameter int OUT_FRAC = 10,
  parameter int OUT_W    = 16
) (
  input  wire signed [P_W-1:0] p,
  output logic [OUT_W-1:0]     r,
  output logic                 clip
);

  localparam int SHIFT = 16 - OUT_FRAC;
  localparam int R_W   = P_W + 1;

  logic signed [R_W-1:0]   rs;
  logic [R_W-OUT_W:0]      hi;

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [R_W-1:0] HALF = {{(R_W-1){1'b0}}, 1'b1} <<< (SHIFT - 1);
      // one extra bit of headroom keeps the rounding add from wrapping
      assign rs = (R_W'(p) + HALF) >>> SHIFT;
    end else begin : g_noround
      assign rs = R_W'(p);
    end
  endgenerate

  assign hi = rs[R_W-1:OUT_W-1];

  always_comb begin
    clip = (hi != '0) && (hi != '1);
    if (clip) begin
      r = rs[R_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      r = rs[OUT_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/pixel_normalizer.sv
`default_nettype none
// pixel_normalizer -- 3-stage per-channel pixel normalizer: subtract/select, multiply, round/saturate.
// Revision: 1.0
module pixel_normalizer
  import pixel_normalizer_pkg::*;
#(
  parameter int IN_W     = 8,
  parameter int OUT_FRAC = 10,
  parameter int OUT_W    = 16,
  parameter int CH       = 3
) (
  input  wire                clk,
  input  wire                rst_n,
  pixel_normalizer_if.slave  bus,
  input  wire                cfg_mode,
  input  wire                cfg_we,
  input  wire [1:0]          cfg_ch,
  input  wire [IN_W-1:0]     cfg_mean,
  input  wire [SCALE_W-1:0]  cfg_scale,
  output logic               busy,
  output logic [15:0]        sat_cnt
);

  localparam int                 D_W        = IN_W + 1;
  localparam int                 P_W        = IN_W + 20;
  localparam logic [SCALE_W-1:0] FULL_SCALE = mode0_scale(IN_W);

  logic                     ce;
  logic [1:0]               ch_cnt;
  logic [1:0]               ch_sel;
  logic [IN_W-1:0]          mean_reg  [CH];
  logic [SCALE_W-1:0]       scale_reg [CH];
  logic [IN_W-1:0]          mean_sel;
  logic [SCALE_W-1:0]       scale_sel;

  logic                     s1_valid;
  logic signed [D_W-1:0]    s1_d;
  logic [SCALE_W-1:0]       s1_scale;
  logic [1:0]               s1_ch;
  logic                     s2_valid;
  logic signed [P_W-1:0]    s2_p;
  logic [1:0]               s2_ch;
  logic [OUT_W-1:0]         rs_data;
  logic                     rs_clip;
  logic                     m_clip;

  assign ce          = !bus.m_valid || bus.m_ready;
  assign bus.s_ready = ce;
  assign ch_sel      = bus.s_sof ? 2'd0 : ch_cnt;
  assign busy        = s1_valid || s2_valid || bus.m_valid;

  always_comb begin
    mean_sel  = '0;
    scale_sel = FULL_SCALE;
    if (cfg_mode == MODE_NORM) begin
      mean_sel  = mean_reg[ch_sel];
      scale_sel = scale_reg[ch_sel];
    end
  end

  // coefficient registers are read combinationally, so a same-cycle write is seen by the next beat only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        mean_reg[i]  <= '0;
        scale_reg[i] <= FULL_SCALE;
      end
    end else if (cfg_we && (int'(cfg_ch) < CH)) begin
      mean_reg[cfg_ch]  <= cfg_mean;
      scale_reg[cfg_ch] <= cfg_scale;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_cnt      <= 2'd0;
      s1_valid    <= 1'b0;
      s1_d        <= '0;
      s1_scale    <= '0;
      s1_ch       <= 2'd0;
      s2_valid    <= 1'b0;
      s2_p        <= '0;
      s2_ch       <= 2'd0;
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      bus.m_ch    <= 2'd0;
      m_clip      <= 1'b0;
    end else if (ce) begin
      s1_valid <= bus.s_valid;
      if (bus.s_valid) begin
        ch_cnt   <= (ch_sel == 2'(CH - 1)) ? 2'd0 : ch_sel + 2'd1;
        s1_d     <= $signed({1'b0, bus.s_data}) - $signed({1'b0, mean_sel});
        s1_scale <= scale_sel;
        s1_ch    <= ch_sel;
      end
      s2_valid    <= s1_valid;
      s2_p        <= P_W'(s1_d) * P_W'($signed({1'b0, s1_scale}));
      s2_ch       <= s1_ch;
      bus.m_valid <= s2_valid;
      bus.m_data  <= rs_data;
      bus.m_ch    <= s2_ch;
      m_clip      <= s2_valid && rs_clip;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= 16'd0;
    end else if (bus.m_valid && bus.m_ready && m_clip && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end

  norm_round_sat #(
    .P_W      (P_W),
    .OUT_FRAC (OUT_FRAC),
    .OUT_W    (OUT_W)
  ) u_round_sat (
    .p    (s2_p),
    .r    (rs_data),
    .clip (rs_clip)
  );

endmodule
`default_nettype wire

// File: doc/pixel_normalizer.md
PIXEL_NORMALIZER -- requirements
Module: pixel_normalizer

Interface
REQ-001 The block SHALL have parameter IN_W, default 8, meaning unsigned pixel width.
REQ-002 The block SHALL have parameter OUT_FRAC, default 10, meaning output fraction bits, in the range 0..16.
REQ-003 The block SHALL have parameter OUT_W, default 16, meaning signed output width (default Q6.10).
REQ-004 The block SHALL have parameter CH, default 3, meaning channel count, in the range 1..4.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock, all logic rising-edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port s_valid / s_ready, input / output, 1 bit each: input handshake.
REQ-008 The block SHALL have port s_data, input, IN_W bits: pixel sample.
REQ-009 The block SHALL have port s_sof, input, 1 bit: first beat of a frame; that beat is forced to channel 0.
REQ-010 The block SHALL have port m_valid / m_ready, output / input, 1 bit each: output handshake.
REQ-011 The block SHALL have port m_data, output, OUT_W bits: signed normalized value.
REQ-012 The block SHALL have port m_ch, output, 2 bits: channel index of m_data.
REQ-013 The block SHALL have port cfg_mode, input, 1 bit: 0 = divide by full scale, 1 = per-channel (x-mean)*scale.
REQ-014 The block SHALL have port cfg_we, input, 1 bit: per-channel coefficient write strobe.
REQ-015 The block SHALL have ports cfg_ch (2 bits), cfg_mean (IN_W bits) and cfg_scale (18 bits, unsigned Q2.16), all inputs.
REQ-016 The block SHALL have port busy, output, 1 bit: high while any pipeline stage holds valid data.
REQ-017 The block SHALL have port sat_cnt, output, 16 bits: count of clipped outputs.

Function
REQ-018 Pipeline SHALL be 3 stages: S1 subtract and coefficient select, S2 multiply, S3 round and saturate. Latency from s accept to m_valid is 3 cycles with m_ready held high.
REQ-019 Stall rule: ce = !m_valid | m_ready; s_ready = ce. All stages advance only when ce=1. No beat is dropped or duplicated under any m_ready pattern.
REQ-020 Full throughput SHALL be one beat per cycle while m_ready=1.
REQ-021 Channel counter SHALL advance on each accepted beat and wrap from CH-1 to 0.
REQ-022 An accepted beat with s_sof=1 SHALL use channel 0, and the counter then advances to 1 (to 0 if CH=1).
REQ-023 Mode 0 SHALL use mean=0 and scale=round(2^16/(2^IN_W-1)), internal constant (257 for IN_W=8).
REQ-024 Mode 1 SHALL use mean_reg[ch] and scale_reg[ch].
REQ-025 Arithmetic: d = x - mean, signed (IN_W+1) bits. p = d*scale, signed (IN_W+20) bits. r = (p + 2^(15-OUT_FRAC)) >>> (16-OUT_FRAC), arithmetic shift. When OUT_FRAC=16, no rounding is applied.
REQ-026 r SHALL saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-027 sat_cnt SHALL increment by 1 per clipped beat as it leaves S3 and SHALL hold at 0xFFFF.
REQ-028 A cfg write SHALL update mean/scale of cfg_ch on the next edge.
REQ-029 A beat accepted in the same cycle as a cfg write to its channel SHALL use the old values.
REQ-030 cfg_ch >= CH SHALL be ignored.
REQ-031 cfg_mode SHALL be sampled per beat at S1, so mixed-mode beats in flight are legal.
REQ-032 m_ch SHALL travel with its data through all stages.

Reset
REQ-033 On rst_n low, stage valids SHALL be 0, m_valid=0, m_data=0, m_ch=0, busy=0, sat_cnt=0, channel counter=0, mean_reg=0, scale_reg=257 (the mode-0 constant). s_ready SHALL be 1 after reset.
REQ-034 Reset mid-stream SHALL discard all in-flight beats; no output beat is produced from pre-reset input.

Structure
REQ-035 A shared package SHALL hold: the Q2.16 scale width (18), the scale fraction bits (16), the mode encodings, and a function computing the mode-0 constant from IN_W.
REQ-036 One sub-module, norm_round_sat (rounding shift plus saturation plus clip flag, combinational), is natural. Everything else stays flat.
REQ-037 Implementation SHALL be vendor-IP-free: a plain multiply, no floating-point cores.

Verification
REQ-038 Mode 0, defaults: inputs 0, 128, 255 -> m_data 0x0000, 0x0202 (514), 0x0400 (1.0), with latency 3.
REQ-039 Mode 1, ch0 mean=128, scale=1024 (std 64): x=192 -> 0x0400; x=0 -> 0xF800 (-2.0); x=128 -> 0x0000.
REQ-040 Saturation: ch1 mean=0, scale=0x3FFFF, x=255 on ch1 -> m_data 0x7FFF and sat_cnt 0->1. Then 0xFFFF+1 clips -> sat_cnt stays 0xFFFF.
REQ-041 Backpressure: stream 20 beats with random m_ready -> output order, values and m_ch sequence 0,1,2,0,... match the model exactly. s_ready=0 whenever m_valid=1 and m_ready=0.
REQ-042 s_sof mid-frame: beats on ch0, ch1, then s_sof -> third beat tagged m_ch=0. A cfg write coincident with acceptance of a ch0 beat -> that beat uses the old coefficients.
REQ-043 Reset with 3 beats in flight -> no m_valid after release, and sat_cnt=0, scale_reg=257.
